muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//   Iterative multi-cycle multiply/divide unit beside the ALU in the EX stage.
//   The ALU has no multiply or divide path, so the EX stage hands M-extension operations here.
//   The EX stage launches with start, stalls on busy and captures result on the done pulse.
//   Shift-add multiply and restoring divide, one bit per cycle.
// PARAMETERS
//   SIZE  64  operand/result width in bits; legal range 8..64, even values only
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   start        in   1       launch request; sampled only while busy==0
//   op           in   3       operation, type md_op_t
//   a            in   SIZE    operand A (dividend / multiplicand)
//   b            in   SIZE    operand B (divisor / multiplier)
//   busy         out  1       operation in flight; start is ignored while high
//   done         out  1       one-cycle pulse; result valid from this cycle onward
//   result       out  SIZE    registered result; holds until the next done
//   div_by_zero  out  1       registered; set with done when a DIV/DIVU/REM/REMU had b==0
// BEHAVIOUR
//   Reset: busy=0, done=0, result='0, div_by_zero=0, FSM in IDLE. Applies asynchronously, including mid-operation.
//   FSM states:
//   - IDLE: on start, latch op and operands (abs values for signed ops, plus sign flags), cnt=0, go to CALC.
//   - CALC: one iteration per cycle; after SIZE iterations go to FIX.
//   - FIX: apply sign correction and special cases, write result and div_by_zero, pulse done, go to IDLE.
//   Latency: start sampled at edge N -> done high in the cycle after edge N+SIZE+1 (SIZE+2 cycles).
//   busy goes high the cycle after the accepting edge and drops in the same cycle done rises.
//   start may be high in the done cycle; it is accepted then (back-to-back, no bubble).
//   Operand changes after the accepting edge have no effect.
//   Multiply: 2*SIZE product register. MUL returns product[SIZE-1:0]; MULHU returns product[2*SIZE-1:SIZE] (unsigned).
//   Divide: quotient and remainder computed on magnitudes.
//   - Signed quotient is negated if sign(a)!=sign(b); signed remainder takes sign(a).
//   - b==0: DIV/DIVU return all ones; REM/REMU return a; div_by_zero=1. Full latency still applies.
//   - Signed overflow (a==MIN, b==-1): DIV returns MIN, REM returns 0, div_by_zero=0.
//   Illegal op codes 6 and 7: accepted, complete at full latency with result='0 and div_by_zero=0.
//   done is never asserted without a preceding accepted start. Reset in any state aborts silently (no done).
// CONFIGURATION
//   MULDIV_EARLY_OUT_EN, when defined:
//   - IDLE jumps straight to FIX when a==0, or b==0, or (op is MUL/MULHU and b==1).
//   - These cases give done 2 cycles after the accepting edge, with the same values as the full path.
//   MULDIV_EARLY_OUT_EN, when undefined: every op takes SIZE+2 cycles (fixed latency).
// STRUCTURE
//   Add to package operations:
//   - typedef enum logic [2:0] md_op_t {MD_MUL=0, MD_MULHU=1, MD_DIV=2, MD_DIVU=3, MD_REM=4, MD_REMU=5}
//   - typedef enum logic [1:0] md_state_t {MD_IDLE, MD_CALC, MD_FIX}
//   Single module, no sub-modules.
//   The iteration counter is $clog2(SIZE)+1 bits. One shared SIZE+1 bit adder/subtractor serves both datapaths.
// TESTING
//   (SIZE=64 unless noted)
//   1. MUL a=7, b=-3 -> result=-21 (0xFFFF_FFFF_FFFF_FFEB); done exactly 66 cycles after start; busy high for 65 cycles.
//   2. MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE.
//   3. DIV a=-7, b=2 -> result=-3; REM a=-7, b=2 -> result=-1; DIVU a=100, b=7 -> 14; REMU a=100, b=7 -> 2.
//   4. DIV a=5, b=0 -> result=all ones, div_by_zero=1; REM a=5, b=0 -> result=5.
//      DIV a=MIN, b=-1 -> MIN with div_by_zero=0.
//   5. Ordering and handshake:
//      - start held high continuously: exactly one op per SIZE+2 cycles, each start taken in the done cycle.
//      - rst_n low during cycle 30 of an op: all outputs 0 at once, no done afterwards; a new op then completes normally.
//   6. With MULDIV_EARLY_OUT_EN: MUL a=0, b=123 -> result=0 with done 2 cycles after start.
//      Without it: same values, 66 cycles. Illegal op=6 -> result=0.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: operation codes, FSM states and op-class helpers for muldiv_unit.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MD_MUL   = 3'd0,
      MD_MULHU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_REM   = 3'd4,
      MD_REMU  = 3'd5
   } md_op_t;

   typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX} md_state_t;

   function automatic logic is_div_op(input logic [2:0] op);
      return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return op == MD_DIV || op == MD_REM;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider, one bit per cycle.
// Define MULDIV_EARLY_OUT_EN to finish a==0, b==0 and multiply-by-one in two cycles.
module muldiv_unit #(
   parameter int SIZE = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] result,
   output logic            div_by_zero
);
   import muldiv_unit_pkg::*;

   localparam int CW = $clog2(SIZE) + 1;

   md_state_t         state, state_nx;
   logic [2:0]        op_q;
   logic [2*SIZE-1:0] prod, prod_init, prod_step;
   logic [SIZE-1:0]   opnd, abs_a, abs_b, hi, lo, res_nx;
   logic [CW-1:0]     cnt;
   logic [SIZE:0]     x, y, sum;
   logic              neg_q, neg_r, bz, sa, sb, early, is_mul, sub, ok;

   assign sa    = is_signed_op(op) & a[SIZE-1];
   assign sb    = is_signed_op(op) & b[SIZE-1];
   assign abs_a = sa ? -a : a;
   assign abs_b = sb ? -b : b;

`ifdef MULDIV_EARLY_OUT_EN
   assign early = a == '0 || b == '0 || ((op == MD_MUL || op == MD_MULHU) && b == SIZE'(1));
`else
   assign early = 1'b0;
`endif

   // Early-out operands preload the final product/quotient image so FIX is shared.
   always_comb begin
      prod_init = is_div_op(op) ? {{SIZE{1'b0}}, abs_a} : {{SIZE{1'b0}}, b};
      if (early)
         prod_init = (is_div_op(op) && b == '0) ? {abs_a, {SIZE{1'b1}}} :
                     (a != '0 && b != '0)       ? {{SIZE{1'b0}}, a} : '0;
   end

   assign hi     = prod[2*SIZE-1:SIZE];
   assign lo     = prod[SIZE-1:0];
   assign is_mul = !is_div_op(op_q);
   assign sub    = !is_mul;
   assign x      = is_mul ? {1'b0, hi} : {hi, lo[SIZE-1]};
   assign y      = {1'b0, opnd};
   assign sum    = x + (y ^ {(SIZE+1){sub}}) + (SIZE+1)'(sub);
   // With a zero divisor the remainder never stays below it, so force the subtract path.
   assign ok     = !sum[SIZE] | bz;

   assign prod_step = is_mul ? (prod[0] ? {sum, lo[SIZE-1:1]} : {1'b0, hi, lo[SIZE-1:1]}) :
                      ok     ? {sum[SIZE-1:0], lo[SIZE-2:0], 1'b1} : {hi[SIZE-2:0], lo, 1'b0};

   always_comb begin
      res_nx = '0;
      case (op_q)
         MD_MUL:   res_nx = lo;
         MD_MULHU: res_nx = hi;
         MD_DIV:   res_nx = bz ? '1 : neg_q ? -lo : lo;
         MD_DIVU:  res_nx = bz ? '1 : lo;
         MD_REM:   res_nx = neg_r ? -hi : hi;
         MD_REMU:  res_nx = hi;
         default:  res_nx = '0;
      endcase
   end

   always_comb begin
      state_nx = (state == MD_IDLE) ? (start ? (early ? MD_FIX : MD_CALC) : MD_IDLE) :
                 (state == MD_CALC) ? ((cnt == CW'(SIZE-1)) ? MD_FIX : MD_CALC) : MD_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= MD_IDLE;
      else        state <= state_nx;

   assign busy = state != MD_IDLE;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         op_q        <= '0;
         prod        <= '0;
         opnd        <= '0;
         cnt         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         bz          <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= state == MD_FIX;
         if (state == MD_IDLE && start) begin
            op_q  <= op;
            prod  <= prod_init;
            opnd  <= is_div_op(op) ? abs_b : a;
            cnt   <= '0;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            bz    <= b == '0;
         end
         if (state == MD_CALC) begin
            prod <= prod_step;
            cnt  <= cnt + 1'b1;
         end
         if (state == MD_FIX) begin
            result      <= res_nx;
            div_by_zero <= bz & is_div_op(op_q);
         end
      end

endmodule
